// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: instruction memory port, redirect port
// and the instruction-register handshake toward decode.
interface fetch_unit_if #(
    parameter int PC_W = 26
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_data;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic [31:0]     ir;
    logic [PC_W-1:0] ir_pc;
    logic            ir_valid;
    logic            ir_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_data,
        input  redirect,
        input  redirect_pc,
        output ir,
        output ir_pc,
        output ir_valid,
        input  ir_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_data,
        output redirect,
        output redirect_pc,
        input  ir,
        input  ir_pc,
        input  ir_valid,
        output ir_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited word reads into a small queue,
// head presented to decode; redirect flushes queue and in-flight read.
module fetch_unit #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 26,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 2;

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] inflight_pc;
    logic            inflight;
    logic [31:0]     q_instr [DEPTH];
    logic [PC_W-1:0] q_pc    [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic issue;
    logic push;
    logic pop;
    logic head_valid;
    logic [CW-1:0] credits_used;

    // Credits use registered state only, so a pop frees a slot next cycle.
    always_comb begin
        head_valid   = (count != '0);
        credits_used = CW'(count) + CW'(inflight);
        issue        = !rst && !bus.redirect
                       && (credits_used < CW'(DEPTH));
        push         = inflight && !bus.redirect;
        pop          = head_valid && bus.ir_ready && !bus.redirect;
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.ir_valid  = head_valid;
    assign bus.ir        = head_valid ? q_instr[rd_ptr] : '0;
    assign bus.ir_pc     = head_valid ? q_pc[rd_ptr] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + PC_W'(1);
                inflight_pc <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= bus.imem_data;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: cycle-level queue model of the fetch front end,
// directed scenarios followed by randomized ready/redirect traffic.
module tb_fetch_unit;
    localparam int              DEPTH    = 4;
    localparam int              PC_W     = 26;
    localparam logic [PC_W-1:0] RESET_PC = '0;

    logic clk;
    logic rst;

    fetch_unit_if #(.PC_W(PC_W)) bus ();

    fetch_unit #(
        .DEPTH(DEPTH),
        .PC_W(PC_W),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] key = 32'h0;

    function automatic logic [31:0] word_of(input logic [PC_W-1:0] a);
        return (32'h1000_0000 + 32'(a)) ^ key;
    endfunction

    // Memory: answers one cycle after a request, junk otherwise.
    always @(posedge clk) begin
        if (bus.imem_req)
            bus.imem_data <= word_of(bus.imem_addr);
        else
            bus.imem_data <= $urandom;
    end

    logic [PC_W-1:0] m_fpc;
    logic [PC_W-1:0] m_ipc;
    bit              m_infl;
    logic [PC_W-1:0] m_q[$];

    task automatic model_reset();
        m_fpc  = RESET_PC;
        m_ipc  = '0;
        m_infl = 1'b0;
        m_q.delete();
    endtask

    // One cycle: drive inputs, compare outputs to the model, advance model.
    task automatic step(input bit rd, input logic [PC_W-1:0] rpc,
                        input bit rdy, input string tag);
        bit              e_req;
        bit              e_val;
        logic [31:0]     e_ir;
        logic [PC_W-1:0] e_pc;
        @(negedge clk);
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.ir_ready    = rdy;
        #1;
        e_req = !rd && ((m_q.size() + int'(m_infl)) < DEPTH);
        e_val = (m_q.size() > 0);
        e_ir  = e_val ? word_of(m_q[0]) : 32'h0;
        e_pc  = e_val ? m_q[0] : '0;
        n_checks++;
        if (bus.imem_req !== e_req || bus.imem_addr !== m_fpc) begin
            n_fail++;
            $display("FAIL %s fetch: req=%b addr=%h, expected req=%b addr=%h",
                     tag, bus.imem_req, bus.imem_addr, e_req, m_fpc);
        end
        n_checks++;
        if (bus.ir_valid !== e_val || bus.ir !== e_ir || bus.ir_pc !== e_pc) begin
            n_fail++;
            $display("FAIL %s decode: valid=%b ir=%h pc=%h, expected valid=%b ir=%h pc=%h",
                     tag, bus.ir_valid, bus.ir, bus.ir_pc, e_val, e_ir, e_pc);
        end
        if (rd) begin
            m_q.delete();
            m_infl = 1'b0;
            m_fpc  = rpc;
        end else begin
            if (e_val && rdy) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_ipc);
            m_infl = e_req;
            if (e_req) begin
                m_ipc = m_fpc;
                m_fpc = m_fpc + PC_W'(1);
            end
        end
    endtask

    task automatic do_reset(input logic [31:0] new_key);
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.ir_ready    = 1'b0;
        key             = new_key;
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b0 || bus.imem_addr !== RESET_PC ||
            bus.ir_valid !== 1'b0 || bus.ir !== 32'h0 || bus.ir_pc !== '0) begin
            n_fail++;
            $display("FAIL reset_state: req=%b addr=%h valid=%b ir=%h pc=%h, expected 0 %h 0 0 0",
                     bus.imem_req, bus.imem_addr, bus.ir_valid, bus.ir, bus.ir_pc, RESET_PC);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(32'h0);
    endtask

    task automatic test_stream();
        do_reset(32'h0);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, "stream");
    endtask

    task automatic test_backpressure();
        do_reset(32'h0);
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b0, "fill");
        step(1'b0, '0, 1'b1, "single_pop");
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, "refill");
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1, "drain");
    endtask

    task automatic test_redirect();
        do_reset(32'h0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, "pre_redirect");
        step(1'b1, PC_W'(32'h15), 1'b0, "redirect");
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, "post_redirect");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "b2b_pre");
        step(1'b1, PC_W'(32'h8), 1'b1, "b2b_first");
        step(1'b1, PC_W'(32'h20), 1'b1, "b2b_second");
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, "b2b_post");
    endtask

    task automatic test_wrap();
        step(1'b1, PC_W'(32'h3FF_FFFE), 1'b1, "wrap_redirect");
        for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, "wrap");
    endtask

    task automatic test_async_reset();
        do_reset(32'h0);
        for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b0, "async_fill");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.imem_req !== 1'b0 || bus.ir_valid !== 1'b0 || bus.ir !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: req=%b valid=%b ir=%h, expected 0 0 0",
                     bus.imem_req, bus.ir_valid, bus.ir);
        end
        do_reset(32'h5A5A_0000);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, "after_reset");
    endtask

    task automatic test_random();
        do_reset($urandom);
        for (int i = 0; i < 500; i++) begin
            bit              rd;
            bit              rdy;
            logic [PC_W-1:0] rpc;
            rd  = ($urandom_range(0, 99) < 6);
            rdy = ($urandom_range(0, 99) < 65);
            rpc = PC_W'($urandom);
            if ($urandom_range(0, 3) == 0) rpc = PC_W'(32'h3FF_FFFD);
            step(rd, rpc, rdy, "random");
        end
    endtask

    initial begin
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.ir_ready    = 1'b0;
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that sits directly upstream of the single-cycle decode/execute datapath. It owns the fetch program counter and issues word reads to the instruction memory. Returned instruction words are buffered in a small FIFO, and presented to decode as an instruction register (`ir`) plus its PC over a valid/ready handshake. Branch and jump targets resolved downstream are applied through a single redirect port that flushes all buffered and in-flight fetches.

## Interface

Parameters:
- `DEPTH`, 4: instruction queue entries (power of two, ≥ 2).
- `PC_W`, 26: PC width; PC is word-addressed, sequential step is +1.
- `RESET_PC`, 0: fetch PC loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  read request to instruction memory this cycle.
- `imem_addr`  out  PC_W  word address of the request (equals fetch PC).
- `imem_data`  in  32  instruction word; valid exactly one cycle after the cycle `imem_req` was high.
- `redirect`  in  1  one-cycle pulse: flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  PC_W  new fetch target (branch or jump address, zero-extended by the producer).
- `ir`  out  32  instruction at queue head; 0 when `ir_valid`=0.
- `ir_pc`  out  PC_W  PC of `ir`; 0 when `ir_valid`=0.
- `ir_valid`  out  1  queue non-empty.
- `ir_ready`  in  1  decode accepts head this cycle.

## Operation

- State:
  - `fetch_pc` (PC_W);
  - `inflight` flag, plus the PC of the in-flight request;
  - circular queue of DEPTH {instr, pc} entries;
  - read/write pointers of log2(DEPTH) bits;
  - occupancy count of log2(DEPTH)+1 bits.
- Issue rule: `imem_req` = !rst && !redirect && (count + inflight < DEPTH).
  - Uses registered values only; a same-cycle pop does not free a credit.
  - `imem_addr` = `fetch_pc` at all times.
  - On issue: `fetch_pc` ← `fetch_pc`+1, modulo 2^PC_W (2^PC_W−1 wraps to 0). `inflight` ← 1 and the request PC is latched; otherwise `inflight` ← 0.
- Response: in any cycle with `inflight`=1 and no `redirect`, push {`imem_data`, latched PC} at the write pointer.
- Pop: when `ir_valid` && `ir_ready` && !`redirect`, advance the read pointer.
- Push and pop in the same cycle leave count unchanged. Overflow is impossible by the credit rule and is not checked at runtime.
- Redirect has priority over issue, push and pop. In that cycle:
  - count ← 0 and both pointers ← 0;
  - `inflight` ← 0, so the response arriving this cycle is discarded;
  - `fetch_pc` ← `redirect_pc`;
  - no request is issued.
- Back-to-back redirects: the last one wins; no request is issued while `redirect` is high.
- Head entry is read combinationally from registered storage; no bypass from `imem_data` to `ir`.

## Timing

- Reset values (asynchronous, immediate on `rst`):
  - `fetch_pc`=RESET_PC, count=0, pointers=0, `inflight`=0.
  - Hence `imem_req`=0, `imem_addr`=RESET_PC, `ir_valid`=0, `ir`=0, `ir_pc`=0.
- `rst` asserted mid-operation drops all queued and in-flight instructions. A memory response arriving in the cycle after `rst` deasserts is ignored.
- Fetch-to-decode latency is 2 cycles:
  - request in cycle N;
  - data captured at the end of cycle N+1;
  - `ir_valid`=1 in cycle N+2.
- First `imem_req` is in the first cycle after `rst` deasserts; first `ir_valid` follows two cycles later.
- Redirect penalty: `redirect` in cycle R → request for `redirect_pc` in R+1 → `ir_valid` with `ir_pc`=`redirect_pc` in R+3. `ir_valid`=0 in R+1 and R+2.
- Sustained throughput with `ir_ready` held high is one instruction per cycle.
- With `ir_ready`=0, the queue fills to DEPTH and `imem_req` stays low until a pop. Issue resumes the cycle after the pop.
- `ir`/`ir_pc` stay stable while `ir_valid`=1 and `ir_ready`=0.

## Test plan

- Reset, `ir_ready`=1, memory returns word = 0x1000_0000 + addr → `imem_addr` 0,1,2,… on consecutive cycles; `ir_valid` from cycle 2; `ir`/`ir_pc` = 0x1000_0000/0, 0x1000_0001/1, … with no bubbles.
- `ir_ready`=0 from reset → exactly 4 requests (addr 0–3), then `imem_req`=0. Count reaches 4 and `ir` holds addr 0's word. Raise `ir_ready` for one cycle → one pop, next request at addr 4 one cycle later.
- `redirect`=1 with `redirect_pc`=0x15 while the queue holds 3 entries and one fetch is in flight → `ir_valid`=0 for 2 cycles, the in-flight word is never presented, next `ir_pc`=0x15 three cycles after the redirect.
- Redirect in two consecutive cycles to 0x8 then 0x20 → single request stream starting at 0x20; 0x8 is never requested.
- `redirect_pc`=0x3FF_FFFE, `ir_ready`=1 → requests 0x3FF_FFFE, 0x3FF_FFFF, 0x000_0000; `ir_pc` sequence matches.
- Assert `rst` asynchronously mid-stream with a full queue → `ir_valid` and `imem_req` go 0 immediately. After release, fetch restarts at RESET_PC and no pre-reset instruction appears.
